// File: rtl/gat_perf_monitor_if.sv
// Stage handshake strobes and BRAM write probe observed by gat_perf_monitor.
// The pipeline side drives through master; the monitor only listens through slave.
interface gat_perf_monitor_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_CH-1:0] vld;
  logic [NUM_CH-1:0] rdy;
  logic              probe_en;
  logic [ADDR_W-1:0] probe_addr;
  logic [DATA_W-1:0] probe_data;

  modport master (output vld, rdy, probe_en, probe_addr, probe_data);
  modport slave  (input  vld, rdy, probe_en, probe_addr, probe_data);
endinterface

// File: rtl/gat_perf_monitor.sv
// Per-stage sticky flags, valid-to-ready latency and valid-pulse counters, plus one
// address-triggered probe capture, read out through a registered channel-select mux.
module gat_perf_monitor #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CAP_LAST = 0,
  parameter int unsigned SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  gat_perf_monitor_if.slave   bus,
  input  logic [ADDR_W-1:0]   trig_addr_i,
  input  logic [SEL_W-1:0]    sel_i,
  output logic [3*NUM_CH:0]   status_o,
  output logic [CNT_W-1:0]    lat_o,
  output logic [CNT_W-1:0]    evt_o,
  output logic [DATA_W-1:0]   cap_o
);

  localparam logic [1:0]       StIdle = 2'd0;
  localparam logic [1:0]       StRun  = 2'd1;
  localparam logic [1:0]       StDone = 2'd2;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [NUM_CH-1:0] vld_seen_q, rdy_seen_q, done;
  logic [CNT_W-1:0]  lat_arr [NUM_CH];
  logic [CNT_W-1:0]  evt_arr [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, lat_q, lat_d, evt_q, evt_d;
    logic             vld_prev_q;

    always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      lat_d   = lat_q;
      case (state_q)
        StIdle: begin
          if (bus.vld[c] && bus.rdy[c]) begin
            state_d = StDone;
            lat_d   = '0;
          end else if (bus.vld[c]) begin
            state_d = StRun;
            cyc_d   = CNT_W'(1);
          end
        end
        StRun: begin
          if (bus.rdy[c]) begin
            state_d = StDone;
            lat_d   = cyc_q;
          end else if (cyc_q != CntMax) begin
            cyc_d = cyc_q + CNT_W'(1);
          end
        end
        default: ;  // StDone holds its measurement until clear
      endcase
      evt_d = evt_q;
      if (bus.vld[c] && !vld_prev_q && (evt_q != CntMax)) evt_d = evt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= StIdle;
        cyc_q      <= '0;
        lat_q      <= '0;
        evt_q      <= '0;
        vld_prev_q <= 1'b0;
      end else if (clr_i) begin
        state_q    <= StIdle;
        cyc_q      <= '0;
        lat_q      <= '0;
        evt_q      <= '0;
        vld_prev_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        cyc_q      <= cyc_d;
        lat_q      <= lat_d;
        evt_q      <= evt_d;
        vld_prev_q <= bus.vld[c];
      end
    end

    assign done[c]    = (state_q == StDone);
    assign lat_arr[c] = lat_q;
    assign evt_arr[c] = evt_q;
  end

  logic              hit, cap_load, cap_hit_q;
  logic [DATA_W-1:0] cap_q;
  logic [CNT_W-1:0]  lat_sel, evt_sel, lat_o_q, evt_o_q;

  assign hit      = bus.probe_en && (bus.probe_addr == trig_addr_i);
  assign cap_load = hit && ((CAP_LAST != 0) || !cap_hit_q);

  // Out-of-range selects fall through the loop and read as zero.
  always_comb begin
    lat_sel = '0;
    evt_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (32'(sel_i) == c) begin
        lat_sel = lat_arr[c];
        evt_sel = evt_arr[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_seen_q <= '0;
      rdy_seen_q <= '0;
      cap_hit_q  <= 1'b0;
      cap_q      <= '0;
      lat_o_q    <= '0;
      evt_o_q    <= '0;
    end else if (clr_i) begin
      vld_seen_q <= '0;
      rdy_seen_q <= '0;
      cap_hit_q  <= 1'b0;
      cap_q      <= '0;
      lat_o_q    <= '0;
      evt_o_q    <= '0;
    end else begin
      vld_seen_q <= vld_seen_q | bus.vld;
      rdy_seen_q <= rdy_seen_q | bus.rdy;
      if (hit)      cap_hit_q <= 1'b1;
      if (cap_load) cap_q     <= bus.probe_data;
      lat_o_q    <= lat_sel;
      evt_o_q    <= evt_sel;
    end
  end

  assign status_o = {cap_hit_q, done, rdy_seen_q, vld_seen_q};
  assign lat_o    = lat_o_q;
  assign evt_o    = evt_o_q;
  assign cap_o    = cap_q;

endmodule

// File: tb/tb_gat_perf_monitor.sv
// Bench for gat_perf_monitor: a 4-channel/32-bit/keep-first instance and a 3-channel/4-bit/
// keep-last instance share stimulus and are checked against an edge-timestamp model.
module tb_gat_perf_monitor;

  localparam longint MaxA = 64'd4294967295;
  localparam longint MaxB = 64'd15;
  localparam logic [15:0] Trig = 16'd43328;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] trig = Trig;
  logic [1:0]  sel = 2'd0;

  logic [12:0] status_a;
  logic [31:0] lat_a, evt_a, cap_a;
  logic [9:0]  status_b;
  logic [3:0]  lat_b, evt_b;
  logic [31:0] cap_b;

  gat_perf_monitor_if #(.NUM_CH(4), .ADDR_W(16), .DATA_W(32)) bus_a ();
  gat_perf_monitor_if #(.NUM_CH(3), .ADDR_W(16), .DATA_W(32)) bus_b ();

  assign bus_b.vld        = bus_a.vld[2:0];
  assign bus_b.rdy        = bus_a.rdy[2:0];
  assign bus_b.probe_en   = bus_a.probe_en;
  assign bus_b.probe_addr = bus_a.probe_addr;
  assign bus_b.probe_data = bus_a.probe_data;

  gat_perf_monitor #(.NUM_CH(4), .CNT_W(32), .ADDR_W(16), .DATA_W(32), .CAP_LAST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .bus(bus_a), .trig_addr_i(trig), .sel_i(sel),
    .status_o(status_a), .lat_o(lat_a), .evt_o(evt_a), .cap_o(cap_a)
  );

  gat_perf_monitor #(.NUM_CH(3), .CNT_W(4), .ADDR_W(16), .DATA_W(32), .CAP_LAST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .bus(bus_b), .trig_addr_i(trig), .sel_i(sel),
    .status_o(status_b), .lat_o(lat_b), .evt_o(evt_b), .cap_o(cap_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: each channel remembers the edge index of its start and finish.
  longint      m_edge;
  longint      m_start [4];
  longint      m_end [4];
  longint      m_evt [4];
  bit          m_prev [4];
  bit          m_vseen [4];
  bit          m_rseen [4];
  bit          m_hit;
  logic [31:0] m_cap_first, m_cap_last;
  longint      m_lat_a, m_evt_a, m_lat_b, m_evt_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_start[c] = -1;
      m_end[c]   = -1;
      m_evt[c]   = 0;
      m_prev[c]  = 1'b0;
      m_vseen[c] = 1'b0;
      m_rseen[c] = 1'b0;
    end
    m_hit = 1'b0;
    m_cap_first = '0;
    m_cap_last = '0;
    m_lat_a = 0;
    m_evt_a = 0;
    m_lat_b = 0;
    m_evt_b = 0;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic longint lat_of(input int c, input longint mx);
    if (m_end[c] < 0) return 0;
    return sat(m_end[c] - m_start[c], mx);
  endfunction

  function automatic logic [63:0] exp_status(input int n);
    logic [63:0] s;
    s = '0;
    for (int c = 0; c < n; c++) begin
      s[c]       = m_vseen[c];
      s[n + c]   = m_rseen[c];
      s[2*n + c] = (m_end[c] >= 0);
    end
    s[3*n] = m_hit;
    return s;
  endfunction

  task automatic check_all();
    check("status_a", 64'(status_a), exp_status(4));
    check("lat_a", 64'(lat_a), 64'(m_lat_a));
    check("evt_a", 64'(evt_a), 64'(m_evt_a));
    check("cap_a", 64'(cap_a), 64'(m_cap_first));
    check("status_b", 64'(status_b), exp_status(3));
    check("lat_b", 64'(lat_b), 64'(m_lat_b));
    check("evt_b", 64'(evt_b), 64'(m_evt_b));
    check("cap_b", 64'(cap_b), 64'(m_cap_last));
  endtask

  // Advance the model over the coming edge using current inputs, clock it, then compare.
  task automatic step();
    longint la, ea, lb, eb;
    int s;
    s  = int'(sel);
    la = lat_of(s, MaxA);
    ea = sat(m_evt[s], MaxA);
    lb = (s < 3) ? lat_of(s, MaxB) : 0;
    eb = (s < 3) ? sat(m_evt[s], MaxB) : 0;
    m_edge++;
    if (clr) begin
      model_reset();
    end else begin
      m_lat_a = la;
      m_evt_a = ea;
      m_lat_b = lb;
      m_evt_b = eb;
      for (int c = 0; c < 4; c++) begin
        if (bus_a.vld[c]) m_vseen[c] = 1'b1;
        if (bus_a.rdy[c]) m_rseen[c] = 1'b1;
        if (bus_a.vld[c] && !m_prev[c]) m_evt[c]++;
        m_prev[c] = bus_a.vld[c];
        if (m_end[c] < 0) begin
          if (m_start[c] < 0) begin
            if (bus_a.vld[c]) begin
              m_start[c] = m_edge;
              if (bus_a.rdy[c]) m_end[c] = m_edge;
            end
          end else if (bus_a.rdy[c]) begin
            m_end[c] = m_edge;
          end
        end
      end
      if (bus_a.probe_en && bus_a.probe_addr == trig) begin
        if (!m_hit) m_cap_first = bus_a.probe_data;
        m_cap_last = bus_a.probe_data;
        m_hit = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_in(input logic [3:0] v, input logic [3:0] r);
    bus_a.vld = v;
    bus_a.rdy = r;
  endtask

  task automatic probe(input logic en, input logic [15:0] a, input logic [31:0] d);
    bus_a.probe_en   = en;
    bus_a.probe_addr = a;
    bus_a.probe_data = d;
  endtask

  task automatic do_clr();
    set_in(4'b0, 4'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_status_a"}, 64'(status_a), 64'd0);
    check({tag, "_lat_a"}, 64'(lat_a), 64'd0);
    check({tag, "_evt_a"}, 64'(evt_a), 64'd0);
    check({tag, "_cap_a"}, 64'(cap_a), 64'd0);
    check({tag, "_status_b"}, 64'(status_b), 64'd0);
    check({tag, "_cap_b"}, 64'(cap_b), 64'd0);
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic [1:0]  sel;
    logic [12:0] status;
    logic [31:0] lat;
    logic [31:0] evt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{4'b0001, 4'b0000, 2'd0, 13'h001, 32'd0, 32'd0};
    tbl[1] = '{4'b0000, 4'b0000, 2'd0, 13'h001, 32'd0, 32'd1};
    tbl[2] = '{4'b0000, 4'b0001, 2'd0, 13'h111, 32'd0, 32'd1};
    tbl[3] = '{4'b0010, 4'b0010, 2'd0, 13'h333, 32'd2, 32'd1};
    tbl[4] = '{4'b0001, 4'b0000, 2'd1, 13'h333, 32'd0, 32'd1};
    tbl[5] = '{4'b0001, 4'b0000, 2'd0, 13'h333, 32'd2, 32'd2};
    tbl[6] = '{4'b0100, 4'b1000, 2'd2, 13'h3B7, 32'd0, 32'd0};
    tbl[7] = '{4'b0000, 4'b0000, 2'd2, 13'h3B7, 32'd0, 32'd1};
    tbl[8] = '{4'b0000, 4'b0100, 2'd2, 13'h7F7, 32'd0, 32'd1};
    tbl[9] = '{4'b0000, 4'b0000, 2'd2, 13'h7F7, 32'd2, 32'd1};

    m_edge = 0;
    set_in(4'b0, 4'b0);
    probe(1'b0, 16'd0, 32'd0);

    // Power-on reset: outputs must clear without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Table of hand-derived vectors for the 4-channel instance.
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].vld, tbl[i].rdy);
      sel = tbl[i].sel;
      step();
      check($sformatf("tbl%0d_status", i), 64'(status_a), 64'(tbl[i].status));
      check($sformatf("tbl%0d_lat", i), 64'(lat_a), 64'(tbl[i].lat));
      check($sformatf("tbl%0d_evt", i), 64'(evt_a), 64'(tbl[i].evt));
    end

    // Latency: valid at cycle 10, ready at cycle 17.
    sel = 2'd1;
    do_clr();
    for (int i = 1; i < 20; i++) begin
      set_in((i == 10) ? 4'b0010 : 4'b0000, (i == 17) ? 4'b0010 : 4'b0000);
      step();
    end
    check("t2_lat_a", 64'(lat_a), 64'd7);
    check("t2_lat_b", 64'(lat_b), 64'd7);
    check("t2_done_a", 64'(status_a[11:8]), 64'b0010);

    // Same-cycle valid/ready, then a run long enough to saturate the 4-bit counter.
    sel = 2'd0;
    do_clr();
    set_in(4'b0001, 4'b0001);
    step();
    set_in(4'b0, 4'b0);
    step();
    check("t3_lat0_a", 64'(lat_a), 64'd0);
    check("t3_done0_a", 64'(status_a[8]), 64'd1);
    do_clr();
    set_in(4'b0001, 4'b0);
    step();
    set_in(4'b0, 4'b0);
    for (int i = 0; i < 20; i++) step();
    set_in(4'b0, 4'b0001);
    step();
    set_in(4'b0, 4'b0);
    step();
    check("t3_sat_a", 64'(lat_a), 64'd21);
    check("t3_sat_b", 64'(lat_b), 64'd15);

    // Event counting: a 5-cycle level counts once, then three single pulses.
    sel = 2'd2;
    do_clr();
    set_in(4'b0100, 4'b0);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 3; i++) begin
      set_in(4'b0000, 4'b0);
      step();
      set_in(4'b0100, 4'b0);
      step();
    end
    set_in(4'b0, 4'b0);
    step();
    step();
    check("t4_evt_a", 64'(evt_a), 64'd4);
    for (int i = 0; i < 20; i++) begin
      set_in(4'b0100, 4'b0);
      step();
      set_in(4'b0000, 4'b0);
      step();
    end
    step();
    check("t4_evt_sat_a", 64'(evt_a), 64'd24);
    check("t4_evt_sat_b", 64'(evt_b), 64'd15);

    // Capture: first hit kept by A, last hit kept by B.
    do_clr();
    probe(1'b1, Trig, 32'hA);
    step();
    probe(1'b1, Trig ^ 16'h0001, 32'hC);
    step();
    probe(1'b0, Trig, 32'hD);
    step();
    probe(1'b1, Trig, 32'hB);
    step();
    probe(1'b0, 16'd0, 32'd0);
    step();
    check("t5_cap_a", 64'(cap_a), 64'hA);
    check("t5_cap_b", 64'(cap_b), 64'hB);
    check("t5_hit_a", 64'(status_a[12]), 64'd1);
    check("t5_hit_b", 64'(status_b[9]), 64'd1);

    // Clear wins over a same-cycle valid; out-of-range select reads zero.
    set_in(4'b1111, 4'b0);
    step();
    set_in(4'b1000, 4'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_zero("t6");
    set_in(4'b0111, 4'b0);
    step();
    set_in(4'b0, 4'b0);
    sel = 2'd2;
    step();
    check("t6_evt2_a", 64'(evt_a), 64'd1);
    sel = 2'd3;
    step();
    step();
    check("t6_sel3_lat_b", 64'(lat_b), 64'd0);
    check("t6_sel3_evt_b", 64'(evt_b), 64'd0);

    // Asynchronous reset in the middle of a measurement.
    for (int i = 0; i < 30; i++) begin
      set_in(4'($urandom), 4'($urandom));
      probe(1'($urandom), ($urandom_range(0, 1) == 0) ? Trig : 16'($urandom), $urandom);
      sel = 2'($urandom);
      step();
    end
    do_clr();
    set_in(4'b0001, 4'b0);
    step();
    set_in(4'b0, 4'b0);
    step();
    #2 rst_n = 1'b0;
    #1 check_zero("t1_async");
    set_in(4'b1111, 4'b1111);
    @(posedge clk);
    #1 check_zero("t1_held");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(4'b0, 4'b0001);
    step();
    check("t1_idle_done0", 64'(status_a[8]), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] v, r;
      for (int c = 0; c < 4; c++) begin
        v[c] = ($urandom_range(0, 3) == 0);
        r[c] = ($urandom_range(0, 5) == 0);
      end
      set_in(v, r);
      probe(1'($urandom), ($urandom_range(0, 3) == 0) ? Trig : 16'($urandom), $urandom);
      sel = 2'($urandom);
      clr = ($urandom_range(0, 99) == 0);
      step();
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
